// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
//   WB_XLEN  : default datapath width of a writeback payload
//   wb_req_t : one writeback request (destination register + data)
//   REG_X0   : architectural zero register; writes to it are dropped
package rf_wb_arbiter_pkg;

  localparam int WB_XLEN = 32;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/rf_wb_arbiter_starve_ctr.sv
// wb_starve_ctr: saturating count of consecutive cycles the LSU lost arbitration.
// Ports:
//   aclk, areset : clock, async active-high reset
//   inc          : LSU requested and lost this cycle
//   clr          : LSU won or is not requesting (has priority over inc)
//   sat          : count has reached STARVE_LIMIT
module wb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic aclk,
  input  logic areset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  logic [CW-1:0] count;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT_C)) begin
      count <= count + 1'b1;
    end
  end

  assign sat = (count == LIMIT_C);

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single regfile write port between the ALU and LSU
// writeback paths. ALU has fixed priority; the LSU is forced through once it has
// lost STARVE_LIMIT consecutive cycles. Writes to x0 are accepted and dropped
// without using the port. The write port outputs are registered.
// Ports:
//   aclk, areset                  : clock, async active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data : ALU writeback handshake + payload
//   lsu_valid/lsu_ready/lsu_rd/lsu_data : LSU writeback handshake + payload
//   write_en, rd, rd_data         : registered regfile write port
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int XLEN         = WB_XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            write_en,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rd_data
);

  logic alu_x0, lsu_x0;
  logic alu_req, lsu_req;
  logic grant_alu, grant_lsu;
  logic starved;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;

  // x0 requests are swallowed here so they never compete for the port.
  assign alu_x0  = alu_valid && (alu_rd == REG_X0);
  assign lsu_x0  = lsu_valid && (lsu_rd == REG_X0);
  assign alu_req = alu_valid && !alu_x0;
  assign lsu_req = lsu_valid && !lsu_x0;

  always_comb begin
    grant_lsu = lsu_req && (!alu_req || starved);
    grant_alu = alu_req && !grant_lsu;
    win_rd    = alu_rd;
    win_data  = alu_data;
    if (grant_lsu) begin
      win_rd   = lsu_rd;
      win_data = lsu_data;
    end
  end

  // Readys are gated by reset so nothing handshakes while areset is high.
  assign alu_ready = !areset && (alu_x0 || grant_alu);
  assign lsu_ready = !areset && (lsu_x0 || grant_lsu);

  // An x0-only LSU request neither counts as losing nor clears the history.
  wb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .aclk   (aclk),
    .areset (areset),
    .inc    (lsu_req && !grant_lsu),
    .clr    (grant_lsu || !lsu_valid),
    .sat    (starved)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      write_en <= 1'b0;
      rd       <= '0;
      rd_data  <= '0;
    end else if (grant_alu || grant_lsu) begin
      write_en <= 1'b1;
      rd       <= win_rd;
      rd_data  <= win_data;
    end else begin
      write_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  logic        aclk = 1'b0;
  logic        areset;
  logic        alu_valid, lsu_valid;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_data, lsu_data;
  logic        write_en;
  logic [4:0]  rd;
  logic [31:0] rd_data;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] rf [32];
  logic        x0_hit;

  always #5 aclk = ~aclk;

  rf_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .write_en  (write_en),
    .rd        (rd),
    .rd_data   (rd_data)
  );

  // Regfile stand-in: commits whatever the port presents at each rising edge.
  always @(posedge aclk) begin
    if (!areset && write_en) begin
      rf[rd] <= rd_data;
      if (rd == 5'd0) x0_hit <= 1'b1;
    end
  end

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'h0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_0055;
    next_cycle();
    vectors++;
    if (write_en !== 1'b0 || rd !== 5'd0 || rd_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: write_en=%b rd=%0d rd_data=%h, want 0/0/0", write_en, rd, rd_data);
    end
    vectors++;
    if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: alu_ready=%b lsu_ready=%b, want 0/0", alu_ready, lsu_ready);
    end
    areset = 1'b0;
    idle_inputs();
    next_cycle();
    // Present a request, then hit reset before it can transfer.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_0055;
    #1;
    vectors++;
    if (alu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_ready: alu_ready=%b, want 1", alu_ready);
    end
    #2 areset = 1'b1;
    #1;
    vectors++;
    if (alu_ready !== 1'b0 || lsu_ready !== 1'b0 || write_en !== 1'b0) begin
      miscompares++;
      $display("FAIL midreq_reset: alu_ready=%b lsu_ready=%b write_en=%b, want 0/0/0",
               alu_ready, lsu_ready, write_en);
    end
    next_cycle();
    areset = 1'b0;
    idle_inputs();
    next_cycle();
    next_cycle();
    vectors++;
    if (write_en !== 1'b0 || rd !== 5'd0) begin
      miscompares++;
      $display("FAIL no_x5_after_reset: write_en=%b rd=%0d, want 0/0", write_en, rd);
    end
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_0055;
    next_cycle();
    idle_inputs();
    vectors++;
    if (write_en !== 1'b1 || rd !== 5'd5 || rd_data !== 32'h0000_0055) begin
      miscompares++;
      $display("FAIL represent_x5: write_en=%b rd=%0d rd_data=%h, want 1/5/00000055",
               write_en, rd, rd_data);
    end
    next_cycle();
  endtask

  task automatic test_alu_only();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEAD_BEEF;
    #1;
    vectors++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_only_ready: alu_ready=%b lsu_ready=%b, want 1/0", alu_ready, lsu_ready);
    end
    next_cycle();
    idle_inputs();
    vectors++;
    if (write_en !== 1'b1 || rd !== 5'd3 || rd_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL alu_only_write: write_en=%b rd=%0d rd_data=%h, want 1/3/deadbeef",
               write_en, rd, rd_data);
    end
  endtask

  task automatic test_idle_hold();
    next_cycle();
    vectors++;
    if (write_en !== 1'b0 || rd !== 5'd3 || rd_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL idle_hold: write_en=%b rd=%0d rd_data=%h, want 0/3/deadbeef",
               write_en, rd, rd_data);
    end
  endtask

  task automatic test_starvation();
    logic exp_lsu;
    for (int i = 1; i <= 6; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1000_0000 + 32'(i);
      lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h0000_00AA;
      exp_lsu = (i == 5);
      #1;
      vectors++;
      if (alu_ready !== !exp_lsu || lsu_ready !== exp_lsu) begin
        miscompares++;
        $display("FAIL starve_ready_c%0d: alu_ready=%b lsu_ready=%b, want %b/%b",
                 i, alu_ready, lsu_ready, !exp_lsu, exp_lsu);
      end
      next_cycle();
      vectors++;
      if (exp_lsu) begin
        if (write_en !== 1'b1 || rd !== 5'd2 || rd_data !== 32'h0000_00AA) begin
          miscompares++;
          $display("FAIL starve_write_c%0d: write_en=%b rd=%0d rd_data=%h, want 1/2/000000aa",
                   i, write_en, rd, rd_data);
        end
      end else begin
        if (write_en !== 1'b1 || rd !== 5'd1 || rd_data !== 32'h1000_0000 + 32'(i)) begin
          miscompares++;
          $display("FAIL starve_write_c%0d: write_en=%b rd=%0d rd_data=%h, want 1/1/%h",
                   i, write_en, rd, rd_data, 32'h1000_0000 + 32'(i));
        end
      end
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_x0_filter();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD0_BAD0;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h7777_0007;
    #1;
    vectors++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL x0_both_ready: alu_ready=%b lsu_ready=%b, want 1/1", alu_ready, lsu_ready);
    end
    next_cycle();
    idle_inputs();
    vectors++;
    if (write_en !== 1'b1 || rd !== 5'd7 || rd_data !== 32'h7777_0007) begin
      miscompares++;
      $display("FAIL x0_lsu_write: write_en=%b rd=%0d rd_data=%h, want 1/7/77770007",
               write_en, rd, rd_data);
    end
    next_cycle();
  endtask

  task automatic test_same_rd();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h2;
    next_cycle();
    alu_valid = 1'b0;
    vectors++;
    if (write_en !== 1'b1 || rd !== 5'd9 || rd_data !== 32'h1) begin
      miscompares++;
      $display("FAIL same_rd_first: write_en=%b rd=%0d rd_data=%h, want 1/9/1", write_en, rd, rd_data);
    end
    #1;
    vectors++;
    if (lsu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL same_rd_lsu_ready: lsu_ready=%b, want 1", lsu_ready);
    end
    next_cycle();
    idle_inputs();
    vectors++;
    if (write_en !== 1'b1 || rd !== 5'd9 || rd_data !== 32'h2) begin
      miscompares++;
      $display("FAIL same_rd_second: write_en=%b rd=%0d rd_data=%h, want 1/9/2", write_en, rd, rd_data);
    end
    next_cycle();
    vectors++;
    if (rf[9] !== 32'h2) begin
      miscompares++;
      $display("FAIL x9_final: rf[9]=%h, want 2", rf[9]);
    end
    vectors++;
    if (x0_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_never_written: x0_hit=%b, want 0", x0_hit);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    x0_hit = 1'b0;
    test_reset();
    test_alu_only();
    test_idle_hold();
    test_starvation();
    test_x0_filter();
    test_same_rd();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
